// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory port arbiter.
// Holds the sequencer state encoding, the port-owner encoding and the latency ceiling.
package mem_arb_pkg;
   localparam int MEM_LAT_MAX = 15;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
   typedef enum logic {OWN_IF, OWN_D} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the port arbiter.
// slave is the arbiter's view; master is the view of the pipeline plus memory model.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ready;
   logic          if_stall;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ready;
   logic          d_stall;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch and data ports, alternating priority on contention.
// Request-to-ready is MEM_LAT+2 cycles; the losing side stalls until the winner's ready pulse retires.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);
   localparam int CW = $clog2(MEM_LAT + 1);

   if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT out of range");
   end

   state_t        state, state_nxt;
   owner_t        owner, last_grant, grant_owner;
   logic          grant;
   logic          done;
   logic [CW-1:0] cnt;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] if_rdata_q, d_rdata_q;
   logic          if_ready_q, d_ready_q;

   assign done = (state == WAIT) && (cnt == '0);

   // D wins a tie unless it was the last side served
   always_comb begin
      state_nxt   = state;
      grant       = 1'b0;
      grant_owner = OWN_IF;
      case (state)
         IDLE: begin
            if (bus.d_req && (!bus.if_req || last_grant == OWN_IF)) begin
               grant       = 1'b1;
               grant_owner = OWN_D;
               state_nxt   = ACCESS;
            end else if (bus.if_req) begin
               grant       = 1'b1;
               state_nxt   = ACCESS;
            end
         end
         ACCESS:  state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= OWN_IF;
         last_grant <= OWN_IF;
         cnt        <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
      end else begin
         state      <= state_nxt;
         if_ready_q <= done && (owner == OWN_IF);
         d_ready_q  <= done && (owner == OWN_D);
         if (grant) begin
            owner <= grant_owner;
            if (grant_owner == OWN_D) begin
               addr_q  <= bus.d_addr;
               we_q    <= bus.d_we;
               wdata_q <= bus.d_wdata;
            end else begin
               addr_q  <= bus.if_addr;
               we_q    <= 1'b0;
               wdata_q <= '0;
            end
         end
         if (state == ACCESS)
            cnt <= CW'(MEM_LAT - 1);
         else if (state == WAIT && cnt != '0)
            cnt <= cnt - 1'b1;
         // stores leave the load-data register untouched
         if (done) begin
            if (owner == OWN_IF)
               if_rdata_q <= bus.mem_rdata;
            else if (!we_q)
               d_rdata_q <= bus.mem_rdata;
         end
         if (state == RESP)
            last_grant <= owner;
      end
   end

   assign bus.mem_en    = (state == ACCESS);
   assign bus.mem_we    = we_q && (state == ACCESS);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_ready  = if_ready_q;
   assign bus.if_stall  = bus.if_req & ~if_ready_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.d_stall   = bus.d_req & ~d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives three arbiters (MEM_LAT 2, 1, 15) against fixed-latency memory models.
// Expected grant order, timing and data come from a transaction-level reference model.
module tb_mem_port_arbiter;
   typedef struct {
      int          kg;
      int          kr;
      bit          side_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] data;
   } ev_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   lat_a [3] = '{2, 1, 15};

   logic        rst_a [3];
   logic        if_req_a [3];
   logic [31:0] if_addr_a [3];
   logic        d_req_a [3];
   logic        d_we_a [3];
   logic [31:0] d_addr_a [3];
   logic [31:0] d_wdata_a [3];
   logic        if_ready_a [3], if_stall_a [3], d_ready_a [3], d_stall_a [3];
   logic        mem_en_a [3], mem_we_a [3];
   logic [31:0] if_rdata_a [3], d_rdata_a [3], mem_addr_a [3], mem_wdata_a [3];

   bit          last_d_a [3];
   logic [31:0] exp_ifrd [3];
   logic [31:0] exp_drd [3];
   logic [31:0] ref_mem [logic [63:0]];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEADBEEF;
      return (a * 32'h0100_0193) ^ 32'hC0DE_F00D;
   endfunction

   function automatic logic [31:0] ref_rd(input int g, input logic [31:0] a);
      logic [63:0] key;
      key = {32'(g), a};
      return ref_mem.exists(key) ? ref_mem[key] : init_val(a);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 15;
      mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
      mem_port_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) dut (
         .clk   (clk),
         .reset (rst_a[g]),
         .bus   (bus)
      );
      assign bus.if_req    = if_req_a[g];
      assign bus.if_addr   = if_addr_a[g];
      assign bus.d_req     = d_req_a[g];
      assign bus.d_we      = d_we_a[g];
      assign bus.d_addr    = d_addr_a[g];
      assign bus.d_wdata   = d_wdata_a[g];
      assign if_ready_a[g] = bus.if_ready;
      assign if_stall_a[g] = bus.if_stall;
      assign if_rdata_a[g] = bus.if_rdata;
      assign d_ready_a[g]  = bus.d_ready;
      assign d_stall_a[g]  = bus.d_stall;
      assign d_rdata_a[g]  = bus.d_rdata;
      assign mem_en_a[g]   = bus.mem_en;
      assign mem_we_a[g]   = bus.mem_we;
      assign mem_addr_a[g] = bus.mem_addr;
      assign mem_wdata_a[g] = bus.mem_wdata;

      // Memory presents read data only in the cycle exactly LAT after mem_en
      logic [31:0] marr [logic [31:0]];
      int          due_q [$];
      logic [31:0] dat_q [$];
      logic [31:0] rdv = '0;
      assign bus.mem_rdata = rdv;
      always @(negedge clk) begin
         while (due_q.size() > 0 && due_q[0] < cyc) begin
            void'(due_q.pop_front());
            void'(dat_q.pop_front());
         end
         if (due_q.size() > 0 && due_q[0] == cyc) rdv = dat_q[0];
         else rdv = 32'hBAD0_0000 | {16'h0, cyc[15:0]};
         if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) marr[bus.mem_addr] = bus.mem_wdata;
            due_q.push_back(cyc + LAT);
            dat_q.push_back(marr.exists(bus.mem_addr) ? marr[bus.mem_addr] : init_val(bus.mem_addr));
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // n_if fetches and n_d data accesses, each side re-requesting as soon as it sees ready
   task automatic txn(input int g, input int n_if, input int n_d, input bit we,
                      input logic [31:0] ia0, input logic [31:0] da0, input logic [31:0] wd0);
      ev_t  evq [$];
      ev_t  ev;
      int   cur = 0, j_if = 0, j_d = 0, done_if = 0, done_d = 0;
      int   lat = lat_a[g];
      bit   last = last_d_a[g];
      bit   emen, er_if, er_d;
      ev_t  e_mem, e_if, e_d;
      while (j_if < n_if || j_d < n_d) begin
         ev.side_d = (j_d < n_d) && (j_if >= n_if || !last);
         ev.kg     = cur;
         ev.kr     = cur + lat + 2;
         ev.we     = ev.side_d && we;
         ev.addr   = ev.side_d ? da0 + 32'(4 * j_d) : ia0 + 32'(4 * j_if);
         ev.wd     = ev.side_d ? wd0 + 32'(j_d) : 32'h0;
         if (ev.we) ref_mem[{32'(g), ev.addr}] = ev.wd;
         ev.data   = ref_rd(g, ev.addr);
         if (ev.side_d) j_d++; else j_if++;
         last = ev.side_d;
         cur += lat + 3;
         evq.push_back(ev);
      end
      last_d_a[g]  = last;
      if_req_a[g]  = (n_if > 0);
      if_addr_a[g] = ia0;
      d_req_a[g]   = (n_d > 0);
      d_we_a[g]    = we;
      d_addr_a[g]  = da0;
      d_wdata_a[g] = wd0;
      for (int k = 1; k <= cur + 1; k++) begin
         @(negedge clk);
         emen = 0; er_if = 0; er_d = 0;
         e_mem = evq[0]; e_if = evq[0]; e_d = evq[0];
         foreach (evq[i]) begin
            if (evq[i].kg + 1 == k) begin emen = 1; e_mem = evq[i]; end
            if (evq[i].kr == k && !evq[i].side_d) begin er_if = 1; e_if = evq[i]; end
            if (evq[i].kr == k && evq[i].side_d) begin er_d = 1; e_d = evq[i]; end
         end
         chk($sformatf("g%0d k%0d mem_en", g, k), 32'(mem_en_a[g]), 32'(emen));
         if (emen) begin
            chk($sformatf("g%0d k%0d mem_addr", g, k), mem_addr_a[g], e_mem.addr);
            chk($sformatf("g%0d k%0d mem_we", g, k), 32'(mem_we_a[g]), 32'(e_mem.we));
            if (e_mem.we) chk($sformatf("g%0d k%0d mem_wdata", g, k), mem_wdata_a[g], e_mem.wd);
         end
         chk($sformatf("g%0d k%0d if_ready", g, k), 32'(if_ready_a[g]), 32'(er_if));
         chk($sformatf("g%0d k%0d d_ready", g, k), 32'(d_ready_a[g]), 32'(er_d));
         chk($sformatf("g%0d k%0d if_stall", g, k), 32'(if_stall_a[g]), 32'(if_req_a[g] & ~er_if));
         chk($sformatf("g%0d k%0d d_stall", g, k), 32'(d_stall_a[g]), 32'(d_req_a[g] & ~er_d));
         if (er_if) begin
            exp_ifrd[g] = e_if.data;
            chk($sformatf("g%0d k%0d if_rdata", g, k), if_rdata_a[g], exp_ifrd[g]);
         end
         if (er_d) begin
            if (!e_d.we) exp_drd[g] = e_d.data;
            chk($sformatf("g%0d k%0d d_rdata", g, k), d_rdata_a[g], exp_drd[g]);
         end
         if (if_ready_a[g] === 1'b1 && if_req_a[g]) begin
            done_if++;
            if (done_if < n_if) if_addr_a[g] = ia0 + 32'(4 * done_if);
            else if_req_a[g] = 1'b0;
         end
         if (d_ready_a[g] === 1'b1 && d_req_a[g]) begin
            done_d++;
            if (done_d < n_d) begin
               d_addr_a[g]  = da0 + 32'(4 * done_d);
               d_wdata_a[g] = wd0 + 32'(done_d);
            end else d_req_a[g] = 1'b0;
         end
      end
      if_req_a[g] = 1'b0;
      d_req_a[g]  = 1'b0;
   endtask

   task automatic chk_zero(input int g, input string when);
      chk($sformatf("g%0d %s mem_en", g, when), 32'(mem_en_a[g]), 32'h0);
      chk($sformatf("g%0d %s mem_we", g, when), 32'(mem_we_a[g]), 32'h0);
      chk($sformatf("g%0d %s mem_addr", g, when), mem_addr_a[g], 32'h0);
      chk($sformatf("g%0d %s mem_wdata", g, when), mem_wdata_a[g], 32'h0);
      chk($sformatf("g%0d %s if_rdata", g, when), if_rdata_a[g], 32'h0);
      chk($sformatf("g%0d %s d_rdata", g, when), d_rdata_a[g], 32'h0);
      chk($sformatf("g%0d %s if_ready", g, when), 32'(if_ready_a[g]), 32'h0);
      chk($sformatf("g%0d %s d_ready", g, when), 32'(d_ready_a[g]), 32'h0);
      chk($sformatf("g%0d %s stalls", g, when), 32'({if_stall_a[g], d_stall_a[g]}), 32'h0);
   endtask

   initial begin
      for (int g = 0; g < 3; g++) begin
         rst_a[g] = 1'b1; if_req_a[g] = 1'b0; if_addr_a[g] = '0;
         d_req_a[g] = 1'b0; d_we_a[g] = 1'b0; d_addr_a[g] = '0; d_wdata_a[g] = '0;
         last_d_a[g] = 1'b0; exp_ifrd[g] = '0; exp_drd[g] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 3; g++) chk_zero(g, "reset");
      for (int g = 0; g < 3; g++) rst_a[g] = 1'b0;

      // Contention straight out of reset: D, IF, D, IF
      txn(0, 2, 2, 1'b0, 32'h100, 32'h200, 32'h0);
      txn(0, 0, 1, 1'b0, 32'h0, 32'h40, 32'h0);
      txn(0, 0, 1, 1'b1, 32'h0, 32'h10, 32'h1234);
      txn(0, 0, 1, 1'b0, 32'h0, 32'h10, 32'h0);

      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk($sformatf("idle %0d mem_en", k), 32'(mem_en_a[0]), 32'h0);
         chk($sformatf("idle %0d stalls", k), 32'({if_stall_a[0], d_stall_a[0]}), 32'h0);
      end

      txn(1, 1, 0, 1'b0, 32'h8, 32'h0, 32'h0);
      txn(2, 1, 0, 1'b0, 32'h8, 32'h0, 32'h0);

      // Reset lands while the load sits in WAIT
      d_req_a[0] = 1'b1; d_we_a[0] = 1'b0; d_addr_a[0] = 32'h80;
      repeat (2) @(negedge clk);
      rst_a[0] = 1'b1; d_req_a[0] = 1'b0;
      @(negedge clk);
      chk_zero(0, "midreset");
      rst_a[0] = 1'b0;
      last_d_a[0] = 1'b0; exp_ifrd[0] = '0; exp_drd[0] = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("post-reset %0d d_ready", k), 32'(d_ready_a[0]), 32'h0);
         chk($sformatf("post-reset %0d mem_en", k), 32'(mem_en_a[0]), 32'h0);
      end
      txn(0, 0, 1, 1'b0, 32'h0, 32'h80, 32'h0);

      for (int it = 0; it < 14; it++) begin
         int g;
         g = int'($urandom_range(0, 2));
         txn(g, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             {26'h0, 4'($urandom_range(0, 15)), 2'b00}, {26'h0, 4'($urandom_range(0, 15)), 2'b00},
             $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch port (IF) and data-access port (MEM stage). It accepts a request from each side, grants one at a time with alternating priority on contention, drives the memory for exactly one access cycle, and returns the result with a one-cycle ready pulse. It sits between the pipeline (IF PC/instruction path, MEM ALU-address/store-data path) and the memory model, and its stall outputs feed the pipeline's stall control.

## Interface
- MEM_LAT, 2: cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- AW, 32: address width
- DW, 32: data width

- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word; valid while if_ready=1, holds value otherwise
- if_ready  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_ready (combinational)
- d_req  in  1  data request; d_we/d_addr/d_wdata held stable until d_ready
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; updated only on load completion
- d_ready  out  1  one-cycle completion pulse for data (loads and stores)
- d_stall  out  1  d_req & ~d_ready (combinational)
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  AW  registered access address
- mem_wdata  out  DW  registered store data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle

## Operation
- States: IDLE, ACCESS, WAIT, RESP. Owner register: IF or D. Last-grant register: IF or D.
- IDLE: only d_req -> grant D; only if_req -> grant IF; both -> grant the side that is not last-grant; neither -> stay. A grant latches owner, the address, we (0 for IF) and wdata into the mem_* registers and goes to ACCESS.
- ACCESS: mem_en=1 for this cycle only. Load counter with MEM_LAT-1, then go to WAIT. Counter width $clog2(MEM_LAT+1).
- WAIT: decrement the counter. When the counter reaches 0, capture mem_rdata into the owner's rdata register (not for stores) and go to RESP.
- RESP: assert the owner's ready for one cycle, update last-grant to the owner, go to IDLE. Requests are not sampled in RESP.
- A req seen in IDLE is always treated as a new request. A requester must drop or replace req at the same edge where it samples ready=1.
- The non-owner's request waits and is served next. With both requesters continuously active, grants alternate D, IF, D, IF, and neither side starves.
- Store: d_ready pulses and d_rdata is unchanged.
- Reset (at any time, including mid-access): state=IDLE, owner=IF, last-grant=IF (so D wins the first contention), counter=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, if_rdata=d_rdata=0, if_ready=d_ready=0. An access in flight is abandoned with no ready pulse.

## Timing
- Req first seen in IDLE at cycle t gives mem_en at t+1, mem_rdata captured at t+1+MEM_LAT, and ready at t+2+MEM_LAT.
- Request-to-ready latency is MEM_LAT+2 cycles. Occupancy is MEM_LAT+3 cycles per access including the return to IDLE.
- MEM_LAT=1: WAIT lasts one cycle (counter loaded with 0).
- Back-to-back: the earliest next grant is in IDLE, one cycle after RESP.
- Ready pulses are registered outputs. Stall outputs are combinational from req and registered ready.

## Structure
- Shared package mem_arb_pkg: state enum (IDLE, ACCESS, WAIT, RESP), owner enum (OWN_IF, OWN_D), MEM_LAT_MAX=15.
- Single module with no sub-module. The counter and priority pick are small enough to stay inline.

## Test plan
- Single load, MEM_LAT=2: d_req, d_addr=0x40, mem_rdata=0xDEADBEEF at the capture cycle. Required: mem_en exactly once at t+1 with mem_addr=0x40, d_ready at t+4, d_rdata=0xDEADBEEF.
- Store: d_we=1, d_addr=0x10, d_wdata=0x1234. Required: mem_en=mem_we=1 for one cycle with mem_wdata=0x1234; d_ready at t+4; d_rdata unchanged.
- Contention after reset: if_req and d_req both asserted continuously. Required: grant order D, IF, D, IF; each ready spaced 5 cycles apart; if_stall stays high until its ready.
- MEM_LAT=1 and MEM_LAT=15 fetch at if_addr=0x8. Required: if_ready at t+3 and t+17 respectively; if_rdata equals mem_rdata sampled at t+2 and t+16.
- Reset mid-WAIT: assert reset during WAIT of a load. Required: no d_ready pulse; all outputs 0 on the next cycle; the re-issued d_req completes normally in MEM_LAT+2 cycles.
- Idle: no req for 20 cycles. Required: mem_en=0 throughout and both stall outputs 0.
